// File: rtl/hazard_controller_if.sv
// Hazard controller pipeline-side bundle: ID/EX/MEM/WB hazard inputs plus
// stall/flush/forwarding controls, state and performance outputs.
// master = pipeline side (drives hazard inputs), slave = hazard controller.
interface hazard_controller_if;
  // ID-stage sources
  logic [3:0]  id_rn;
  logic [3:0]  id_rm;
  logic [3:0]  id_rd;
  logic        id_uses_rn;
  logic        id_uses_rm;
  logic        id_uses_rd;
  logic        id_branch_taken;
  // Downstream destinations
  logic [3:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_is_load;
  logic [3:0]  mem_rd;
  logic        mem_reg_write;
  logic [3:0]  wb_rd;
  logic        wb_reg_write;
  logic        ext_stall_req;
  // Controls and status
  logic        pc_enable;
  logic        if_id_enable;
  logic        cu_mux_nop;
  logic        if_id_flush;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic [1:0]  fwd_d;
  logic [1:0]  state;
  logic [15:0] stall_count;
  logic [15:0] flush_count;
  logic        hold_timeout;

  modport master (
    output id_rn, id_rm, id_rd, id_uses_rn, id_uses_rm, id_uses_rd,
           id_branch_taken, ex_rd, ex_reg_write, ex_is_load,
           mem_rd, mem_reg_write, wb_rd, wb_reg_write, ext_stall_req,
    input  pc_enable, if_id_enable, cu_mux_nop, if_id_flush,
           fwd_a, fwd_b, fwd_d, state, stall_count, flush_count, hold_timeout
  );

  modport slave (
    input  id_rn, id_rm, id_rd, id_uses_rn, id_uses_rm, id_uses_rd,
           id_branch_taken, ex_rd, ex_reg_write, ex_is_load,
           mem_rd, mem_reg_write, wb_rd, wb_reg_write, ext_stall_req,
    output pc_enable, if_id_enable, cu_mux_nop, if_id_flush,
           fwd_a, fwd_b, fwd_d, state, stall_count, flush_count, hold_timeout
  );
endinterface

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use stall, operand forwarding, branch flush, external hold.
// Latency: stall/flush/bubble/forward outputs are combinational in the same cycle; state and counters registered.
// Backpressure: ext_stall_req freezes PC and IF/ID and bubbles the control mux until released.
// Ports: clk, reset (sync, active-high); hz (slave) carries ID/EX/MEM/WB hazard inputs and all controls/status.
module hazard_controller #(
  parameter int HOLD_LIMIT = 255
) (
  input  logic                clk,
  input  logic                reset,
  hazard_controller_if.slave  hz
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    FLUSH = 2'b01,
    HOLD  = 2'b10
  } state_t;

  // One spare code above HOLD_LIMIT keeps the width non-zero for tiny limits.
  localparam int HW = $clog2(HOLD_LIMIT + 2);

  state_t      st;
  state_t      nxt;
  logic        pending_flush;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
  logic [HW-1:0] hold_cnt;
  logic        timeout;

  logic        load_use;
  logic        stall;
  logic        flush;
  logic        set_pend;

  function automatic logic src_hit(input logic [3:0] src, input logic uses,
                                   input logic [3:0] dst);
    return uses && (src != 4'd15) && (src == dst);
  endfunction

  function automatic logic [1:0] fwd_sel(
    input logic [3:0] src, input logic uses,
    input logic [3:0] exr, input logic exw, input logic exl,
    input logic [3:0] mr,  input logic mw,
    input logic [3:0] wr,  input logic ww
  );
    // R15 is the PC: never forwarded.
    if (!uses || src == 4'd15)      return 2'b00;
    // A load in EX has no data yet; it is caught by the load-use stall.
    if (exw && !exl && exr == src)  return 2'b01;
    if (mw && mr == src)            return 2'b10;
    if (ww && wr == src)            return 2'b11;
    return 2'b00;
  endfunction

  assign load_use = hz.ex_is_load && hz.ex_reg_write && (hz.ex_rd != 4'd15) &&
                    (src_hit(hz.id_rn, hz.id_uses_rn, hz.ex_rd) ||
                     src_hit(hz.id_rm, hz.id_uses_rm, hz.ex_rd) ||
                     src_hit(hz.id_rd, hz.id_uses_rd, hz.ex_rd));

  always_comb begin
    stall    = 1'b0;
    flush    = 1'b0;
    set_pend = 1'b0;
    nxt      = st;
    case (st)
      RUN: begin
        if (hz.ext_stall_req) begin
          stall    = 1'b1;
          nxt      = HOLD;
          set_pend = hz.id_branch_taken;
        end else if (load_use) begin
          // Branch stays in ID and is re-evaluated after the bubble.
          stall = 1'b1;
        end else if (hz.id_branch_taken) begin
          flush = 1'b1;
          nxt   = FLUSH;
        end
      end
      FLUSH: begin
        // ID holds the squashed slot, so any branch indication is ignored.
        nxt = RUN;
        if (hz.ext_stall_req) begin
          stall = 1'b1;
          nxt   = HOLD;
        end else if (load_use) begin
          stall = 1'b1;
        end
      end
      HOLD: begin
        if (hz.ext_stall_req) begin
          stall    = 1'b1;
          set_pend = hz.id_branch_taken;
        end else if (pending_flush || hz.id_branch_taken) begin
          // Release cycle: the branch held in ID finally squashes IF/ID.
          flush = 1'b1;
          nxt   = FLUSH;
        end else begin
          stall = load_use;
          nxt   = RUN;
        end
      end
      default: nxt = RUN;
    endcase
    if (reset) begin
      stall = 1'b0;
      flush = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st            <= RUN;
      pending_flush <= 1'b0;
      stall_cnt     <= 16'd0;
      flush_cnt     <= 16'd0;
      hold_cnt      <= '0;
      timeout       <= 1'b0;
    end else begin
      st <= nxt;

      if (st == HOLD && !hz.ext_stall_req)
        pending_flush <= 1'b0;
      else if (set_pend)
        pending_flush <= 1'b1;

      if (stall && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
      if (flush && flush_cnt != 16'hFFFF)
        flush_cnt <= flush_cnt + 16'd1;

      // Only stalled HOLD cycles count; the release cycle clears the run.
      if (st == HOLD && hz.ext_stall_req) begin
        if (hold_cnt != HW'(HOLD_LIMIT))
          hold_cnt <= hold_cnt + HW'(1);
        if (hold_cnt == HW'(HOLD_LIMIT - 1))
          timeout <= 1'b1;
      end else begin
        hold_cnt <= '0;
      end
    end
  end

  assign hz.pc_enable    = !stall;
  assign hz.if_id_enable = !stall;
  assign hz.cu_mux_nop   = stall;
  assign hz.if_id_flush  = flush;
  assign hz.fwd_a = reset ? 2'b00 :
    fwd_sel(hz.id_rn, hz.id_uses_rn, hz.ex_rd, hz.ex_reg_write, hz.ex_is_load,
            hz.mem_rd, hz.mem_reg_write, hz.wb_rd, hz.wb_reg_write);
  assign hz.fwd_b = reset ? 2'b00 :
    fwd_sel(hz.id_rm, hz.id_uses_rm, hz.ex_rd, hz.ex_reg_write, hz.ex_is_load,
            hz.mem_rd, hz.mem_reg_write, hz.wb_rd, hz.wb_reg_write);
  assign hz.fwd_d = reset ? 2'b00 :
    fwd_sel(hz.id_rd, hz.id_uses_rd, hz.ex_rd, hz.ex_reg_write, hz.ex_is_load,
            hz.mem_rd, hz.mem_reg_write, hz.wb_rd, hz.wb_reg_write);
  assign hz.state        = st;
  assign hz.stall_count  = stall_cnt;
  assign hz.flush_count  = flush_cnt;
  assign hz.hold_timeout = timeout;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: a table of combinational forwarding /
// load-use vectors, then hand-written multi-cycle sequences for branch flush,
// external hold with pending branch, hold watchdog and reset abort.
module tb_hazard_controller;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  hazard_controller_if hz();

  hazard_controller #(.HOLD_LIMIT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] rn, rm, rd;
    logic       urn, urm, urd;
    logic [3:0] exr;
    logic       exw, exl;
    logic [3:0] mr;
    logic       mw;
    logic [3:0] wr;
    logic       ww;
    logic [1:0] fa, fb, fd;
    logic       stl;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    hz.id_rn = 4'd1; hz.id_rm = 4'd2; hz.id_rd = 4'd3;
    hz.id_uses_rn = 1'b0; hz.id_uses_rm = 1'b0; hz.id_uses_rd = 1'b0;
    hz.id_branch_taken = 1'b0;
    hz.ex_rd = 4'd0; hz.ex_reg_write = 1'b0; hz.ex_is_load = 1'b0;
    hz.mem_rd = 4'd0; hz.mem_reg_write = 1'b0;
    hz.wb_rd = 4'd0; hz.wb_reg_write = 1'b0;
    hz.ext_stall_req = 1'b0;
  endtask

  // Advance one edge and settle past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            name        rn  rm  rd  urn urm urd exr exw exl mr  mw wr  ww  fa  fb  fd  stl
    vecs[0]  = '{"idle",      1,  2,  3,  1,  1,  1,  0,  0,  0,  0,  0, 0,  0,  0,  0,  0,  0};
    vecs[1]  = '{"ex_fwd_b",  1,  5,  3,  1,  1,  1,  5,  1,  0,  5,  1, 0,  0,  0,  1,  0,  0};
    vecs[2]  = '{"mem_fwd_b", 1,  5,  3,  1,  1,  1,  5,  0,  0,  5,  1, 0,  0,  0,  2,  0,  0};
    vecs[3]  = '{"r15_nofwd", 1, 15,  3,  1,  1,  1, 15,  1,  0, 15,  1, 15, 1,  0,  0,  0,  0};
    vecs[4]  = '{"wb_fwd_d",  1,  2,  7,  1,  1,  1,  0,  0,  0,  0,  0, 7,  1,  0,  0,  3,  0};
    vecs[5]  = '{"unused_rn", 4,  2,  3,  0,  1,  1,  4,  1,  0,  0,  0, 0,  0,  0,  0,  0,  0};
    vecs[6]  = '{"ex_prio",   6,  6,  3,  1,  1,  1,  6,  1,  0,  6,  1, 6,  1,  1,  1,  0,  0};
    vecs[7]  = '{"mem_prio",  1,  2,  8,  1,  1,  1,  0,  0,  0,  8,  1, 8,  1,  0,  0,  2,  0};
    vecs[8]  = '{"ldu_rn",    2,  4,  3,  1,  1,  1,  2,  1,  1,  0,  0, 0,  0,  0,  0,  0,  1};
    vecs[9]  = '{"ldu_unused",2,  4,  3,  0,  1,  1,  2,  1,  1,  0,  0, 0,  0,  0,  0,  0,  0};
    vecs[10] = '{"ldu_r15",  15,  4,  3,  1,  1,  1, 15,  1,  1,  0,  0, 0,  0,  0,  0,  0,  0};
    vecs[11] = '{"ld_nowr",   2,  4,  3,  1,  1,  1,  2,  0,  1,  0,  0, 0,  0,  0,  0,  0,  0};
    vecs[12] = '{"ldu_rd",    1,  4,  9,  1,  1,  1,  9,  1,  1,  0,  0, 0,  0,  0,  0,  0,  1};

    // ---- reset: outputs forced benign even with hazards present ----
    idle_inputs();
    reset = 1'b1;
    hz.ext_stall_req = 1'b1;
    hz.id_branch_taken = 1'b1;
    hz.id_rn = 4'd2; hz.id_uses_rn = 1'b1;
    hz.ex_rd = 4'd2; hz.ex_reg_write = 1'b1;
    #1;
    chk("rst_pc_en", 16'(hz.pc_enable), 16'd1);
    chk("rst_ifid_en", 16'(hz.if_id_enable), 16'd1);
    chk("rst_nop", 16'(hz.cu_mux_nop), 16'd0);
    chk("rst_flush", 16'(hz.if_id_flush), 16'd0);
    chk("rst_fwd_a", 16'(hz.fwd_a), 16'd0);
    tick();
    tick();
    chk("rst_state", 16'(hz.state), 16'd0);
    chk("rst_stall_cnt", hz.stall_count, 16'd0);
    chk("rst_flush_cnt", hz.flush_count, 16'd0);
    chk("rst_timeout", 16'(hz.hold_timeout), 16'd0);
    reset = 1'b0;
    idle_inputs();
    tick();

    // ---- table: forwarding and load-use detection in RUN (no clocking) ----
    for (int i = 0; i < 13; i++) begin
      hz.id_rn = vecs[i].rn; hz.id_rm = vecs[i].rm; hz.id_rd = vecs[i].rd;
      hz.id_uses_rn = vecs[i].urn; hz.id_uses_rm = vecs[i].urm; hz.id_uses_rd = vecs[i].urd;
      hz.ex_rd = vecs[i].exr; hz.ex_reg_write = vecs[i].exw; hz.ex_is_load = vecs[i].exl;
      hz.mem_rd = vecs[i].mr; hz.mem_reg_write = vecs[i].mw;
      hz.wb_rd = vecs[i].wr; hz.wb_reg_write = vecs[i].ww;
      #1;
      chk({vecs[i].name, ".fwd_a"}, 16'(hz.fwd_a), 16'(vecs[i].fa));
      chk({vecs[i].name, ".fwd_b"}, 16'(hz.fwd_b), 16'(vecs[i].fb));
      chk({vecs[i].name, ".fwd_d"}, 16'(hz.fwd_d), 16'(vecs[i].fd));
      chk({vecs[i].name, ".pc_en"}, 16'(hz.pc_enable), 16'(!vecs[i].stl));
      chk({vecs[i].name, ".nop"}, 16'(hz.cu_mux_nop), 16'(vecs[i].stl));
      chk({vecs[i].name, ".flush"}, 16'(hz.if_id_flush), 16'd0);
    end
    idle_inputs();
    #1;

    // ---- load-use: one stall cycle, then forward from MEM ----
    hz.id_rn = 4'd2; hz.id_uses_rn = 1'b1;
    hz.ex_rd = 4'd2; hz.ex_reg_write = 1'b1; hz.ex_is_load = 1'b1;
    #1;
    chk("lu_pc_en", 16'(hz.pc_enable), 16'd0);
    chk("lu_ifid_en", 16'(hz.if_id_enable), 16'd0);
    chk("lu_nop", 16'(hz.cu_mux_nop), 16'd1);
    tick();
    hz.ex_reg_write = 1'b0; hz.ex_is_load = 1'b0; hz.ex_rd = 4'd0;
    hz.mem_rd = 4'd2; hz.mem_reg_write = 1'b1;
    #1;
    chk("lu_stall_cnt", hz.stall_count, 16'd1);
    chk("lu_pc_en_after", 16'(hz.pc_enable), 16'd1);
    chk("lu_fwd_a_mem", 16'(hz.fwd_a), 16'd2);
    chk("lu_state", 16'(hz.state), 16'd0);
    tick();
    idle_inputs();
    #1;

    // ---- branch flush; branch held in FLUSH gives no second pulse ----
    hz.id_branch_taken = 1'b1;
    #1;
    chk("br_flush", 16'(hz.if_id_flush), 16'd1);
    chk("br_pc_en", 16'(hz.pc_enable), 16'd1);
    tick();
    chk("br_state_flush", 16'(hz.state), 16'd1);
    chk("br_flush_cnt", hz.flush_count, 16'd1);
    chk("br_no_2nd_pulse", 16'(hz.if_id_flush), 16'd0);
    tick();
    hz.id_branch_taken = 1'b0;
    #1;
    chk("br_state_run", 16'(hz.state), 16'd0);
    chk("br_flush_cnt2", hz.flush_count, 16'd1);

    // ---- ext stall 4 cycles with branch in cycle 1 ----
    for (int c = 1; c <= 4; c++) begin
      hz.ext_stall_req = 1'b1;
      hz.id_branch_taken = (c == 1);
      #1;
      chk($sformatf("hold_pc_en_c%0d", c), 16'(hz.pc_enable), 16'd0);
      chk($sformatf("hold_flush_c%0d", c), 16'(hz.if_id_flush), 16'd0);
      chk($sformatf("hold_state_c%0d", c), 16'(hz.state), (c == 1) ? 16'd0 : 16'd2);
      tick();
    end
    hz.ext_stall_req = 1'b0;
    hz.id_branch_taken = 1'b0;
    #1;
    chk("rel_state", 16'(hz.state), 16'd2);
    chk("rel_pc_en", 16'(hz.pc_enable), 16'd1);
    chk("rel_flush", 16'(hz.if_id_flush), 16'd1);
    tick();
    chk("rel_state_flush", 16'(hz.state), 16'd1);
    chk("rel_flush_cnt", hz.flush_count, 16'd2);
    chk("rel_stall_cnt", hz.stall_count, 16'd5);
    chk("rel_no_flush", 16'(hz.if_id_flush), 16'd0);
    tick();
    chk("rel_state_run", 16'(hz.state), 16'd0);
    chk("short_hold_no_to", 16'(hz.hold_timeout), 16'd0);

    // ---- second short hold: run counter must have cleared ----
    hz.ext_stall_req = 1'b1;
    repeat (6) tick();
    hz.ext_stall_req = 1'b0;
    tick();
    chk("two_holds_no_to", 16'(hz.hold_timeout), 16'd0);
    chk("two_holds_stall_cnt", hz.stall_count, 16'd11);
    chk("two_holds_no_flush", hz.flush_count, 16'd2);

    // ---- watchdog with HOLD_LIMIT=8: ext stall held 10 cycles ----
    hz.ext_stall_req = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("wd_timeout_k%0d", k), 16'(hz.hold_timeout), (k >= 9) ? 16'd1 : 16'd0);
    end
    hz.ext_stall_req = 1'b0;
    tick();
    chk("wd_state_run", 16'(hz.state), 16'd0);
    chk("wd_sticky1", 16'(hz.hold_timeout), 16'd1);
    tick();
    chk("wd_sticky2", 16'(hz.hold_timeout), 16'd1);
    chk("wd_stall_cnt", hz.stall_count, 16'd21);

    // ---- reset during HOLD with pending branch ----
    hz.ext_stall_req = 1'b1;
    hz.id_branch_taken = 1'b1;
    tick();
    hz.id_branch_taken = 1'b0;
    tick();
    chk("rh_state_hold", 16'(hz.state), 16'd2);
    reset = 1'b1;
    #1;
    chk("rh_pc_en_in_rst", 16'(hz.pc_enable), 16'd1);
    tick();
    reset = 1'b0;
    hz.ext_stall_req = 1'b0;
    #1;
    chk("rh_state", 16'(hz.state), 16'd0);
    chk("rh_stall_cnt", hz.stall_count, 16'd0);
    chk("rh_flush_cnt", hz.flush_count, 16'd0);
    chk("rh_timeout", 16'(hz.hold_timeout), 16'd0);
    chk("rh_no_flush", 16'(hz.if_id_flush), 16'd0);
    tick();
    chk("rh_no_flush2", 16'(hz.if_id_flush), 16'd0);
    chk("rh_flush_cnt2", hz.flush_count, 16'd0);

    // ---- load-use and branch together: stall wins, branch next cycle ----
    hz.id_rn = 4'd3; hz.id_uses_rn = 1'b1;
    hz.ex_rd = 4'd3; hz.ex_reg_write = 1'b1; hz.ex_is_load = 1'b1;
    hz.id_branch_taken = 1'b1;
    #1;
    chk("lub_pc_en", 16'(hz.pc_enable), 16'd0);
    chk("lub_flush", 16'(hz.if_id_flush), 16'd0);
    tick();
    chk("lub_state", 16'(hz.state), 16'd0);
    hz.ex_reg_write = 1'b0; hz.ex_is_load = 1'b0;
    hz.mem_rd = 4'd3; hz.mem_reg_write = 1'b1;
    #1;
    chk("lub_flush_next", 16'(hz.if_id_flush), 16'd1);
    tick();
    chk("lub_state_flush", 16'(hz.state), 16'd1);
    chk("lub_flush_cnt", hz.flush_count, 16'd1);

    // ---- ext stall in FLUSH: enters HOLD, squashed branch not remembered ----
    hz.ext_stall_req = 1'b1;
    #1;
    chk("fh_pc_en", 16'(hz.pc_enable), 16'd0);
    tick();
    hz.id_branch_taken = 1'b0;
    chk("fh_state_hold", 16'(hz.state), 16'd2);
    hz.ext_stall_req = 1'b0;
    #1;
    chk("fh_rel_no_flush", 16'(hz.if_id_flush), 16'd0);
    tick();
    chk("fh_state_run", 16'(hz.state), 16'd0);
    chk("fh_stall_cnt", hz.stall_count, 16'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
